// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle processor control path:
// FSM state encodings, opcode numbers, ALU selects and mux encodings.
package cpu_pkg;

    // Opcode field width (instr[31:26])
    localparam int OPW = 6;

    // FSM state encoding (3-bit, FETCH must be zero)
    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_MEM     = 3'd3;
    localparam logic [2:0] ST_WB      = 3'd4;
    localparam logic [2:0] ST_WB_BASE = 3'd5;
    localparam logic [2:0] ST_TRAP    = 3'd6;

    // Opcodes
    localparam logic [5:0] OP_OR     = 6'd0;
    localparam logic [5:0] OP_ADD    = 6'd1;
    localparam logic [5:0] OP_SUB    = 6'd2;
    localparam logic [5:0] OP_CMP    = 6'd3;
    localparam logic [5:0] OP_ORI    = 6'd4;
    localparam logic [5:0] OP_ADDI   = 6'd5;
    localparam logic [5:0] OP_LW     = 6'd6;
    localparam logic [5:0] OP_SW     = 6'd7;
    localparam logic [5:0] OP_LW_POI = 6'd8;
    localparam logic [5:0] OP_SW_POI = 6'd9;
    localparam logic [5:0] OP_JMP    = 6'd10;
    localparam logic [5:0] OP_CALL   = 6'd11;
    localparam logic [5:0] OP_BZ     = 6'd12;

    // ALU operation selects: the ALU decodes the low opcode nibble directly
    localparam logic [3:0] ALU_OR   = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_CMP  = 4'd3;

    // PC source mux
    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_ALU = 2'd1;
    localparam logic [1:0] PC_SRC_RET = 2'd2;

    // Register-file write-back mux
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    // Opcodes whose second ALU operand is the sign-extended immediate
    function automatic logic uses_imm(input logic [5:0] op);
        logic r;
        case (op)
            OP_ORI, OP_ADDI, OP_LW, OP_SW, OP_LW_POI, OP_SW_POI, OP_BZ: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcodes whose memory phase is a write
    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SW_POI);
    endfunction

    // Opcodes whose memory phase is a read
    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LW_POI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe map: state + latched opcode -> datapath controls.
// Holds no state; every output defaults to 0 in states that do not drive it.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0] state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       alu_en,
    output logic [3:0] alu_control,
    output logic       alu_src_b,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       reg_write,
    output logic [1:0] wb_sel
);

    // Per-state strobe generation
    always_comb begin
        alu_en      = 1'b0;
        alu_control = ALU_OR;
        alu_src_b   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_INC;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = WB_SEL_ALU;
        case (state)
            ST_FETCH: begin
                mem_read = 1'b1;
                // IR and PC+1 load only on the cycle the fetch completes
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            ST_EXEC: begin
                alu_en      = 1'b1;
                alu_control = op[3:0];
                alu_src_b   = uses_imm(op);
                case (op)
                    OP_JMP, OP_CALL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALU;
                    end
                    OP_BZ: begin
                        // Zero flag is valid this cycle since the ALU is combinational
                        pc_write = alu_zero;
                        pc_src   = PC_SRC_ALU;
                    end
                    default: begin
                        pc_write = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                if (is_store(op)) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (is_load(op)) begin
                    wb_sel = WB_SEL_MEM;
                end else if (op == OP_CALL) begin
                    wb_sel = WB_SEL_PC;
                end else begin
                    wb_sel = WB_SEL_ALU;
                end
            end
            ST_WB_BASE: begin
                // Post-increment base register update
                reg_write = 1'b1;
                wb_sel    = WB_SEL_ALU;
            end
            default: begin
                // DECODE and TRAP drive no strobes
                alu_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor main control FSM.
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> [WB_BASE] -> FETCH.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (opcodes > 12 trap and set the
// sticky illegal_op flag; otherwise they are treated as a NOP).
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    input  logic           alu_zero,
    output logic           alu_en,
    output logic [3:0]     alu_control,
    output logic           alu_src_b,
    output logic           ir_write,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           mem_read,
    output logic           mem_write,
    output logic           addr_sel,
    output logic           reg_write,
    output logic [1:0]     wb_sel,
    output logic           illegal_op
);

    logic [2:0]     state_r;
    logic [2:0]     next_state_s;
    logic [OPW-1:0] op_q;
    logic           illegal_op_r;
    logic           op_illegal_s;

    logic       d_alu_en_s;
    logic [3:0] d_alu_control_s;
    logic       d_alu_src_b_s;
    logic       d_ir_write_s;
    logic       d_pc_write_s;
    logic [1:0] d_pc_src_s;
    logic       d_mem_read_s;
    logic       d_mem_write_s;
    logic       d_addr_sel_s;
    logic       d_reg_write_s;
    logic [1:0] d_wb_sel_s;

    // The legality check looks at the live opcode so DECODE can branch the
    // same cycle op_q is loaded.
    assign op_illegal_s = (opcode > OPW'(OP_BZ));

    // State and opcode registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op_r <= 1'b0;
        end else if ((state_r == ST_DECODE) && op_illegal_s) begin
            illegal_op_r <= 1'b1;
        end
    end
`else
    // Trap disabled: flag is permanently clear
    always_comb begin
        illegal_op_r = 1'b0;
    end
`endif

    // Next-state sequencing
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (op_illegal_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    next_state_s = ST_TRAP;
`else
                    next_state_s = ST_FETCH;
`endif
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (6'(op_q))
                    OP_OR, OP_ADD, OP_SUB, OP_CMP, OP_ORI, OP_ADDI, OP_CALL:
                        next_state_s = ST_WB;
                    OP_LW, OP_SW, OP_LW_POI, OP_SW_POI:
                        next_state_s = ST_MEM;
                    default:
                        next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    next_state_s = ST_MEM;
                end else begin
                    case (6'(op_q))
                        OP_LW, OP_LW_POI: next_state_s = ST_WB;
                        OP_SW_POI:        next_state_s = ST_WB_BASE;
                        default:          next_state_s = ST_FETCH;
                    endcase
                end
            end
            ST_WB: begin
                if (6'(op_q) == OP_LW_POI) begin
                    next_state_s = ST_WB_BASE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB_BASE: next_state_s = ST_FETCH;
            ST_TRAP:    next_state_s = ST_TRAP;
            default:    next_state_s = ST_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .state       (state_r),
        .op          (6'(op_q)),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .alu_en      (d_alu_en_s),
        .alu_control (d_alu_control_s),
        .alu_src_b   (d_alu_src_b_s),
        .ir_write    (d_ir_write_s),
        .pc_write    (d_pc_write_s),
        .pc_src      (d_pc_src_s),
        .mem_read    (d_mem_read_s),
        .mem_write   (d_mem_write_s),
        .addr_sel    (d_addr_sel_s),
        .reg_write   (d_reg_write_s),
        .wb_sel      (d_wb_sel_s)
    );

    // Output gating: reset forces every strobe low at once, so an in-flight
    // register write or memory access is cut off without waiting for a clock.
    always_comb begin
        if (reset) begin
            alu_en      = 1'b0;
            alu_control = 4'd0;
            alu_src_b   = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'd0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            addr_sel    = 1'b0;
            reg_write   = 1'b0;
            wb_sel      = 2'd0;
            illegal_op  = 1'b0;
        end else begin
            alu_en      = d_alu_en_s;
            alu_control = d_alu_control_s;
            alu_src_b   = d_alu_src_b_s;
            ir_write    = d_ir_write_s;
            pc_write    = d_pc_write_s;
            pc_src      = d_pc_src_s;
            mem_read    = d_mem_read_s;
            mem_write   = d_mem_write_s;
            addr_sel    = d_addr_sel_s;
            reg_write   = d_reg_write_s;
            wb_sel      = d_wb_sel_s;
            illegal_op  = illegal_op_r;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Outputs are packed into one vector and
// compared cycle by cycle against hand-written expectations.
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    logic       alu_en;
    logic [3:0] alu_control;
    logic       alu_src_b;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal_op;
    logic [16:0] obs;

    int n_vec = 0;
    int n_bad = 0;

    multicycle_ctrl #(.OPW(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .alu_en      (alu_en),
        .alu_control (alu_control),
        .alu_src_b   (alu_src_b),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr_sel    (addr_sel),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {alu_en, alu_control, alu_src_b, ir_write, pc_write, pc_src,
                  mem_read, mem_write, addr_sel, reg_write, wb_sel, illegal_op};

    // Build an expected output vector in the same bit order as obs
    function automatic logic [16:0] v(input logic en, input logic [3:0] ctl,
                                      input logic sb, input logic irw,
                                      input logic pcw, input logic [1:0] ps,
                                      input logic mr, input logic mw,
                                      input logic as, input logic rw,
                                      input logic [1:0] ws, input logic il);
        return {en, ctl, sb, irw, pcw, ps, mr, mw, as, rw, ws, il};
    endfunction

    task automatic cmp(input string tag, input logic [16:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (away from the edge) then move to the next one
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        cmp(tag, exp);
        @(negedge clk);
    endtask

    logic [16:0] f_rdy, f_wait, zero_v, wb_alu;

    initial begin
        f_rdy  = v(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        f_wait = v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        zero_v = 17'd0;
        wb_alu = v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);

        reset = 1'b1; mem_ready = 1'b1; opcode = 6'd1; alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        cyc("rst_hold_a", zero_v);
        cyc("rst_hold_b", zero_v);
        reset = 1'b0;

        // ADD: 4 cycles
        cyc("add_fetch", f_rdy);
        cyc("add_decode", zero_v);
        cyc("add_exec", v(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("add_wb", wb_alu);

        // LW.POI with two wait cycles in MEM: 8 cycles
        opcode = 6'd8;
        cyc("lwp_fetch", f_rdy);
        cyc("lwp_decode", zero_v);
        cyc("lwp_exec", v(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        mem_ready = 1'b0;
        cyc("lwp_mem_w1", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        cyc("lwp_mem_w2", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        mem_ready = 1'b1;
        cyc("lwp_mem_rdy", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        cyc("lwp_wb", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0));
        cyc("lwp_wb_base", wb_alu);

        // BZ taken: 3 cycles
        opcode = 6'd12; alu_zero = 1'b1;
        cyc("bz1_fetch", f_rdy);
        cyc("bz1_decode", zero_v);
        cyc("bz1_exec", v(1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));

        // BZ not taken: 3 cycles
        alu_zero = 1'b0;
        cyc("bz0_fetch", f_rdy);
        cyc("bz0_decode", zero_v);
        cyc("bz0_exec", v(1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));

        // CALL: 4 cycles with link write
        opcode = 6'd11;
        cyc("call_fetch", f_rdy);
        cyc("call_decode", zero_v);
        cyc("call_exec", v(1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("call_wb", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0));

        // SW.POI with one fetch stall cycle
        opcode = 6'd9; mem_ready = 1'b0;
        cyc("swp_fetch_wait", f_wait);
        mem_ready = 1'b1;
        cyc("swp_fetch", f_rdy);
        cyc("swp_decode", zero_v);
        cyc("swp_exec", v(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("swp_mem", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0));
        cyc("swp_wb_base", wb_alu);

        // ADD aborted by reset during WB
        opcode = 6'd1;
        cyc("add2_fetch", f_rdy);
        cyc("add2_decode", zero_v);
        cyc("add2_exec", v(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        #1;
        cmp("add2_wb", wb_alu);
        reset = 1'b1;
        #1;
        cmp("add2_wb_reset", zero_v);
        @(negedge clk);
        reset = 1'b0;

        // Illegal opcode 63
        opcode = 6'd63;
        cyc("ill_fetch", f_rdy);
        cyc("ill_decode", zero_v);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) begin
            cyc("ill_trap", v(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
        end
        reset = 1'b1;
        #1;
        cmp("ill_trap_reset", zero_v);
        @(negedge clk);
        reset = 1'b0;
        cyc("ill_after_reset", f_rdy);
`else
        cyc("ill_nop_fetch", f_rdy);
        cyc("ill_nop_decode", zero_v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
